// File: rtl/ws2812_ctrl.sv
// WS2812 LED string controller: CPU-visible RGB frame buffer at $30-$33 and an
// NRZ serialiser that resends the whole string after every buffer/count update.
module ws2812_ctrl #(
    parameter int MAX_LEDS  = 256,
    parameter int T0H_CYC   = 10,
    parameter int T1H_CYC   = 20,
    parameter int BIT_CYC   = 34,
    parameter int RESET_CYC = 1500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       io_req,
    input  logic       io_wr,
    input  logic [1:0] io_addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ws2812_dout,
    output logic       busy
);
    localparam int CW = $clog2(RESET_CYC + BIT_CYC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

    logic [7:0]    led_index_reg, led_count_reg, led_ptr_reg, led_ptr_next;
    logic [1:0]    phase_reg, rd_phase_reg;
    logic          dirty_reg, set_dirty, clr_dirty;
    logic          buf_wr, advance;
    logic [7:0]    rd_byte;
    logic [23:0]   tx_word, shift_reg, shift_next;
    logic [4:0]    bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0] cyc_reg, cyc_next, hi_len, lo_len;
    logic          busy_reg, busy_next, dout_reg;
    state_t        state_reg, state_next;

    assign buf_wr    = io_req && io_wr && (io_addr == 2'd1);
    assign advance   = io_req && (io_addr == 2'd1);
    assign set_dirty = io_req && io_wr && ((io_addr == 2'd1) || (io_addr == 2'd2));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_index_reg <= '0;
            led_count_reg <= '0;
            phase_reg     <= '0;
            rd_phase_reg  <= '0;
        end else begin
            rd_phase_reg <= phase_reg;
            if (io_req && io_wr && (io_addr == 2'd0)) begin
                led_index_reg <= data_in;
                phase_reg     <= '0;
            end else if (advance) begin
                if (phase_reg == 2'd2) begin
                    phase_reg     <= '0;
                    led_index_reg <= (int'(led_index_reg) == MAX_LEDS - 1) ? 8'd0 : led_index_reg + 8'd1;
                end else begin
                    phase_reg <= phase_reg + 2'd1;
                end
            end
            if (io_req && io_wr && (io_addr == 2'd2))
                led_count_reg <= data_in;
        end
    end

    // One byte lane per colour: CPU port (read/write) and transmit port (read) are independent.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] mem [MAX_LEDS];
            logic [7:0] cpu_q;
            logic [7:0] tx_q;

            always_ff @(posedge clk) begin
                if (reset_n && buf_wr && (phase_reg == 2'(gi)))
                    mem[led_index_reg] <= data_in;
                tx_q <= mem[led_ptr_reg];
            end

            always_ff @(posedge clk) begin
                if (!reset_n)
                    cpu_q <= '0;
                else
                    cpu_q <= mem[led_index_reg];
            end
        end
    endgenerate

    always_comb begin
        case (rd_phase_reg)
            2'd0:    rd_byte = g_lane[0].cpu_q;
            2'd1:    rd_byte = g_lane[1].cpu_q;
            default: rd_byte = g_lane[2].cpu_q;
        endcase
    end

    // Wire order is G, R, B.
    assign tx_word = {g_lane[1].tx_q, g_lane[0].tx_q, g_lane[2].tx_q};

    always_comb begin
        case (io_addr)
            2'd0:    data_out = led_index_reg;
            2'd1:    data_out = rd_byte;
            2'd2:    data_out = led_count_reg;
            default: data_out = {7'b0, busy_reg};
        endcase
    end

    assign hi_len = shift_reg[23] ? CW'(T1H_CYC) : CW'(T0H_CYC);
    assign lo_len = CW'(BIT_CYC) - hi_len;

    always_comb begin
        state_next   = state_reg;
        cyc_next     = cyc_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        led_ptr_next = led_ptr_reg;
        busy_next    = busy_reg;
        clr_dirty    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dirty_reg) begin
                    clr_dirty = 1'b1;
                    if (led_count_reg != 8'd0) begin
                        state_next   = LOAD;
                        led_ptr_next = '0;
                        busy_next    = 1'b1;
                        cyc_next     = '0;
                    end
                end
            end
            LOAD: begin
                // First cycle addresses the RAM, second cycle takes its registered output.
                cyc_next = cyc_reg + CW'(1);
                if (cyc_reg == CW'(1)) begin
                    shift_next   = tx_word;
                    bit_cnt_next = 5'd23;
                    cyc_next     = '0;
                    state_next   = HIGH;
                end
            end
            HIGH: begin
                cyc_next = cyc_reg + CW'(1);
                if (cyc_reg == hi_len - CW'(1)) begin
                    cyc_next   = '0;
                    state_next = LOW;
                end
            end
            LOW: begin
                cyc_next = cyc_reg + CW'(1);
                if (cyc_reg == lo_len - CW'(1)) begin
                    cyc_next = '0;
                    if (bit_cnt_reg != 5'd0) begin
                        shift_next   = {shift_reg[22:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg - 5'd1;
                        state_next   = HIGH;
                    end else if (({1'b0, led_ptr_reg} + 9'd1) < {1'b0, led_count_reg}) begin
                        led_ptr_next = led_ptr_reg + 8'd1;
                        state_next   = LOAD;
                    end else begin
                        state_next = LATCH;
                    end
                end
            end
            LATCH: begin
                cyc_next = cyc_reg + CW'(1);
                if (cyc_reg == CW'(RESET_CYC - 1)) begin
                    cyc_next   = '0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cyc_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            led_ptr_reg <= '0;
            busy_reg    <= 1'b0;
            dout_reg    <= 1'b0;
            dirty_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cyc_reg     <= cyc_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            led_ptr_reg <= led_ptr_next;
            busy_reg    <= busy_next;
            dout_reg    <= (state_next == HIGH);
            // A CPU update in the same clk as the IDLE clear must still trigger a frame.
            dirty_reg   <= set_dirty || (dirty_reg && !clr_dirty);
        end
    end

    assign ws2812_dout = dout_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_ws2812_ctrl.sv
// Randomised self-checking bench for ws2812_ctrl: register map, buffer model and
// frame waveform decoding against a byte-level reference of the LED buffer.
module tb_ws2812_ctrl;
    localparam int T0H = 10;
    localparam int T1H = 20;
    localparam int BITC = 34;
    localparam int RST = 1500;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       io_req = 1'b0;
    logic       io_wr = 1'b0;
    logic [1:0] io_addr = 2'd0;
    logic [7:0] data_in = 8'd0;
    logic [7:0] data_out;
    logic       ws2812_dout;
    logic       busy;

    ws2812_ctrl dut (
        .clk(clk), .reset_n(reset_n), .io_req(io_req), .io_wr(io_wr),
        .io_addr(io_addr), .data_in(data_in), .data_out(data_out),
        .ws2812_dout(ws2812_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the CPU-visible state.
    logic [7:0] m_buf [256][3];
    bit         m_valid [256][3];
    int         m_idx = 0;
    int         m_phase = 0;
    int         m_count = 0;

    // Line monitor: cycle stamps of every edge on dout and busy.
    int cyc_n = 0;
    int rise_q[$], fall_q[$], brise_q[$], bfall_q[$];
    logic dout_prev = 1'b0, busy_prev = 1'b0;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (ws2812_dout === 1'b1 && dout_prev === 1'b0) rise_q.push_back(cyc_n);
        if (ws2812_dout === 1'b0 && dout_prev === 1'b1) fall_q.push_back(cyc_n);
        if (busy === 1'b1 && busy_prev === 1'b0) brise_q.push_back(cyc_n);
        if (busy === 1'b0 && busy_prev === 1'b1) bfall_q.push_back(cyc_n);
        dout_prev = ws2812_dout;
        busy_prev = busy;
    end

    task automatic mon_clear();
        rise_q.delete(); fall_q.delete(); brise_q.delete(); bfall_q.delete();
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        m_idx = 0; m_phase = 0; m_count = 0;
    endtask

    task automatic model_adv();
        if (m_phase == 2) begin
            m_phase = 0;
            m_idx = (m_idx + 1) % 256;
        end else begin
            m_phase++;
        end
    endtask

    task automatic cpu_write(input int addr, input logic [7:0] d);
        io_req = 1'b1; io_wr = 1'b1; io_addr = 2'(addr); data_in = d;
        step();
        io_req = 1'b0; io_wr = 1'b0;
        case (addr)
            0: begin m_idx = int'(d); m_phase = 0; end
            1: begin m_buf[m_idx][m_phase] = d; m_valid[m_idx][m_phase] = 1'b1; model_adv(); end
            2: m_count = int'(d);
            default: ;
        endcase
        $display("wr  $3%0d <= 0x%02h", addr, d);
    endtask

    task automatic cpu_read(input int addr);
        io_req = 1'b1; io_wr = 1'b0; io_addr = 2'(addr);
        step();
        io_req = 1'b0;
        if (addr == 1) model_adv();
        $display("rd  $3%0d", addr);
    endtask

    task automatic peek(input int addr, output logic [7:0] v);
        io_addr = 2'(addr);
        step(); step();
        @(negedge clk);
        v = data_out;
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input string tag, input int n);
        int t, nb, led, b, exp_hi, exp_p, last;
        logic [23:0] w;
        t = 0;
        while (bfall_q.size() == 0 && t < n * 24 * BITC + n * 4 + RST + 200) begin
            @(negedge clk); #1; t++;
        end
        checks++;
        if (bfall_q.size() == 0) begin
            errors++;
            $display("FAIL %s_end: busy never fell, rises=%0d", tag, rise_q.size());
        end
        checks++;
        if (brise_q.size() != 1) begin
            errors++;
            $display("FAIL %s_busy_rise: got %0d busy rises, expected 1", tag, brise_q.size());
        end
        checks++;
        if (rise_q.size() != n * 24 || fall_q.size() != n * 24) begin
            errors++;
            $display("FAIL %s_bitcount: got %0d/%0d pulses, expected %0d", tag, rise_q.size(), fall_q.size(), n * 24);
        end
        nb = (rise_q.size() < fall_q.size()) ? rise_q.size() : fall_q.size();
        if (nb > n * 24) nb = n * 24;
        for (int i = 0; i < nb; i++) begin
            led = i / 24;
            b = 23 - (i % 24);
            w = {m_buf[led][1], m_buf[led][0], m_buf[led][2]};
            exp_hi = w[b] ? T1H : T0H;
            checks++;
            if (fall_q[i] - rise_q[i] != exp_hi) begin
                errors++;
                $display("FAIL %s_high[%0d]: got %0d clk, expected %0d", tag, i, fall_q[i] - rise_q[i], exp_hi);
            end
            if (i + 1 < nb) begin
                exp_p = (i % 24 == 23) ? BITC + 2 : BITC;
                checks++;
                if (rise_q[i + 1] - rise_q[i] != exp_p) begin
                    errors++;
                    $display("FAIL %s_period[%0d]: got %0d clk, expected %0d", tag, i, rise_q[i + 1] - rise_q[i], exp_p);
                end
            end
        end
        if (nb > 0 && bfall_q.size() > 0) begin
            last = fall_q[nb - 1];
            checks++;
            if (bfall_q[0] - last < RST) begin
                errors++;
                $display("FAIL %s_latch: got %0d clk low before busy fell, expected >= %0d", tag, bfall_q[0] - last, RST);
            end
        end
        $display("frame %s: %0d LEDs, %0d pulses", tag, n, nb);
        mon_clear();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        for (int a = 0; a < 4; a++) begin
            io_addr = 2'(a);
            @(negedge clk);
            v = data_out;
            checks++;
            if (v !== 8'd0) begin
                errors++;
                $display("FAIL reset_data_out[$3%0d]: got 0x%02h expected 0x00", a, v);
            end
        end
        checks++;
        if (ws2812_dout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: dout=%b busy=%b expected 0 0", ws2812_dout, busy);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        $display("reset released");
    endtask

    task automatic test_buffer_write();
        logic [7:0] v;
        cpu_write(0, 8'd5);
        cpu_write(1, 8'h12);
        cpu_write(1, 8'h34);
        cpu_write(1, 8'h56);
        peek(0, v);
        checks++;
        if (v !== 8'(m_idx)) begin
            errors++;
            $display("FAIL buffer_write_index: got %0d expected %0d", v, m_idx);
        end
    endtask

    task automatic test_readback();
        logic [7:0] v;
        cpu_write(0, 8'd5);
        for (int i = 0; i < 3; i++) begin
            peek(1, v);
            checks++;
            if (v !== m_buf[m_idx][m_phase]) begin
                errors++;
                $display("FAIL readback[%0d]: got 0x%02h expected 0x%02h", i, v, m_buf[m_idx][m_phase]);
            end
            cpu_read(1);
        end
        peek(0, v);
        checks++;
        if (v !== 8'(m_idx)) begin
            errors++;
            $display("FAIL readback_index: got %0d expected %0d", v, m_idx);
        end
    endtask

    task automatic test_index_wrap();
        logic [7:0] v;
        cpu_write(0, 8'd0);
        cpu_write(1, 8'($urandom_range(0, 255)));
        cpu_write(0, 8'd255);
        for (int i = 0; i < 3; i++) cpu_write(1, 8'($urandom_range(0, 255)));
        peek(0, v);
        checks++;
        if (v !== 8'(m_idx)) begin
            errors++;
            $display("FAIL wrap_index: got %0d expected %0d", v, m_idx);
        end
        peek(1, v);
        checks++;
        if (v !== m_buf[0][0]) begin
            errors++;
            $display("FAIL wrap_phase: $31 got 0x%02h expected R byte 0x%02h", v, m_buf[0][0]);
        end
    endtask

    task automatic test_random_rw();
        logic [7:0] v;
        int op;
        cpu_write(0, 8'd8);
        for (int i = 0; i < 24; i++) cpu_write(1, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 50; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: cpu_write(0, 8'($urandom_range(8, 15)));
                1: cpu_write(1, 8'($urandom_range(0, 255)));
                2: begin
                    peek(1, v);
                    if (m_valid[m_idx][m_phase]) begin
                        checks++;
                        if (v !== m_buf[m_idx][m_phase]) begin
                            errors++;
                            $display("FAIL rand_rd31[%0d]: got 0x%02h expected 0x%02h", i, v, m_buf[m_idx][m_phase]);
                        end
                    end
                    cpu_read(1);
                end
                default: begin
                    peek(0, v);
                    checks++;
                    if (v !== 8'(m_idx)) begin
                        errors++;
                        $display("FAIL rand_rd30[%0d]: got %0d expected %0d", i, v, m_idx);
                    end
                end
            endcase
        end
    endtask

    task automatic test_frame();
        logic [7:0] v;
        cpu_write(0, 8'd0);
        cpu_write(1, 8'hFF); cpu_write(1, 8'h00); cpu_write(1, 8'h80);
        cpu_write(1, 8'h00); cpu_write(1, 8'h00); cpu_write(1, 8'h00);
        mon_clear();
        cpu_write(2, 8'd2);
        peek(3, v);
        checks++;
        if (v !== 8'd1) begin
            errors++;
            $display("FAIL frame_busy_reg: $33 got 0x%02h expected 0x01", v);
        end
        check_frame("frame", 2);
    endtask

    task automatic test_random_frame();
        logic [7:0] v;
        int n;
        cpu_write(2, 8'd0);
        n = $urandom_range(1, 4);
        cpu_write(0, 8'd0);
        for (int i = 0; i < 3 * n; i++) cpu_write(1, 8'($urandom_range(0, 255)));
        mon_clear();
        cpu_write(2, 8'(n));
        peek(2, v);
        checks++;
        if (v !== 8'(m_count)) begin
            errors++;
            $display("FAIL count_reg: got %0d expected %0d", v, m_count);
        end
        check_frame("random", n);
    endtask

    task automatic test_zero_count();
        cpu_write(2, 8'd0);
        mon_clear();
        cpu_write(1, 8'($urandom_range(0, 255)));
        cpu_write(2, 8'd0);
        repeat (5000) step();
        checks++;
        if (rise_q.size() != 0 || brise_q.size() != 0) begin
            errors++;
            $display("FAIL zero_count: got %0d pulses %0d busy rises, expected 0 0", rise_q.size(), brise_q.size());
        end
    endtask

    task automatic test_mid_frame_write();
        int t;
        cpu_write(2, 8'd0);
        cpu_write(0, 8'd0);
        for (int i = 0; i < 6; i++) cpu_write(1, 8'($urandom_range(0, 255)));
        cpu_write(0, 8'd1);
        mon_clear();
        cpu_write(2, 8'd2);
        t = 0;
        while (rise_q.size() < 11 && t < 1000) begin @(negedge clk); #1; t++; end
        checks++;
        if (rise_q.size() < 11) begin
            errors++;
            $display("FAIL mid_wait: got %0d pulses, expected >= 11", rise_q.size());
        end
        cpu_write(1, 8'($urandom_range(0, 255)));
        check_frame("mid_first", 2);
        check_frame("mid_second", 2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int t;
        cpu_write(2, 8'd0);
        cpu_write(0, 8'd0);
        for (int i = 0; i < 3; i++) cpu_write(1, 8'($urandom_range(0, 255)));
        cpu_write(0, 8'd77);
        mon_clear();
        cpu_write(2, 8'd1);
        t = 0;
        while (rise_q.size() < 3 && t < 500) begin @(negedge clk); #1; t++; end
        step(); step();
        io_addr = 2'd0;
        @(negedge clk);
        checks++;
        if (ws2812_dout !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: dout=%b busy=%b expected 1 1", ws2812_dout, busy);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v = data_out;
        checks++;
        if (ws2812_dout !== 1'b0 || busy !== 1'b0 || v !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: dout=%b busy=%b $30=%0d expected 0 0 0", ws2812_dout, busy, v);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        $display("reset applied mid-bit");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_buffer_write();
        test_readback();
        test_index_wrap();
        test_random_rw();
        test_frame();
        test_random_frame();
        test_zero_count();
        test_mid_frame_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
